// File: rtl/ddr2_port_arbiter.sv
// ---------------------------------------------------------------------------
// ddr2_port_arbiter
//
// Purpose:
//   Two-requester burst scheduler in front of the DDR2 controller local
//   interface, clocked by phy_clk. The write port carries camera frame-buffer
//   traffic and the read port carries host readout traffic. Each grant issues
//   one fixed-length burst of BURST_LEN beats. Commands are held while
//   local_ready is low. The number of read bursts that are issued but not
//   fully returned is limited to MAX_RD_OUT.
//
// Build option:
//   DDR2_ARB_WRITE_PRIORITY_EN
//     Defined:   an eligible write always wins arbitration in IDLE.
//     Undefined: round-robin between the two ports when both are eligible.
//
// Ports:
//   phy_clk, reset_phy_clk_n   clock and asynchronous active-low reset
//   local_init_done            calibration done; no new grants while low
//   wr_req/wr_addr             write burst request, held until wr_gnt
//   wr_data/wr_data_rd         FWFT write data and its pop strobe
//   wr_gnt                     pulse when the last write beat is accepted
//   rd_req/rd_addr             read burst request, held until rd_gnt
//   rd_gnt                     pulse when the read command is accepted
//   rd_data_valid/rd_data      returned read beats, registered once
//   busy                       burst in progress or reads outstanding
//   local_*                    DDR2 controller local interface
// ---------------------------------------------------------------------------
module ddr2_port_arbiter #(
   parameter int ADDR_W     = 24,
   parameter int DATA_W     = 64,
   parameter int BURST_LEN  = 4,
   parameter int MAX_RD_OUT = 2
) (
   input  logic                phy_clk,
   input  logic                reset_phy_clk_n,
   input  logic                local_init_done,
   input  logic                wr_req,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_data,
   output logic                wr_data_rd,
   output logic                wr_gnt,
   input  logic                rd_req,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic                rd_gnt,
   output logic                rd_data_valid,
   output logic [DATA_W-1:0]   rd_data,
   output logic                busy,
   input  logic                local_ready,
   output logic                local_burstbegin,
   output logic [ADDR_W-1:0]   local_address,
   output logic [3:0]          local_size,
   output logic [DATA_W/8-1:0] local_be,
   output logic                local_write_req,
   output logic [DATA_W-1:0]   local_wdata,
   output logic                local_read_req,
   input  logic                local_rdata_valid,
   input  logic [DATA_W-1:0]   local_rdata
);

   localparam int BCW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
   localparam int OCW = $clog2(MAX_RD_OUT + 1);
   localparam logic [BCW-1:0] LAST_BEAT = BCW'(BURST_LEN - 1);
   localparam logic [OCW-1:0] MAX_OUT   = OCW'(MAX_RD_OUT);

   typedef enum logic [1:0] {S_IDLE, S_WR, S_RD} state_t;
   typedef enum logic {SRV_WRITE, SRV_READ} srv_t;

   state_t             r_state;
   srv_t               r_last_served;
   logic [BCW-1:0]     r_beat_cnt;
   logic [BCW-1:0]     r_ret_cnt;
   logic [OCW-1:0]     r_rd_out;
   logic [ADDR_W-1:0]  r_local_address;
   logic               r_write_req;
   logic               r_read_req;
   logic               r_burstbegin;
   logic               r_rd_data_valid;
   logic [DATA_W-1:0]  r_rd_data;

   logic w_wr_elig;
   logic w_rd_elig;
   logic w_pick_wr;
   logic w_wr_beat_acc;
   logic w_rd_cmd_acc;
   logic w_ret_cnt_en;
   logic w_ret_last;

   assign w_wr_elig     = wr_req;
   assign w_rd_elig     = rd_req & (r_rd_out < MAX_OUT);
   assign w_wr_beat_acc = r_write_req & local_ready;
   assign w_rd_cmd_acc  = r_read_req & local_ready;

`ifdef DDR2_ARB_WRITE_PRIORITY_EN
   assign w_pick_wr = w_wr_elig;
`else
   // With both ports eligible, the port that was not served last goes next.
   assign w_pick_wr = w_wr_elig & (~w_rd_elig | (r_last_served == SRV_READ));
`endif

   // Returns arriving with nothing outstanding are forwarded but not counted.
   assign w_ret_cnt_en = local_rdata_valid & (r_rd_out != '0);
   assign w_ret_last   = w_ret_cnt_en & (r_ret_cnt == LAST_BEAT);

   // Command sequencer
   always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
      if (!reset_phy_clk_n) begin
         r_state         <= S_IDLE;
         r_last_served   <= SRV_READ;
         r_beat_cnt      <= '0;
         r_local_address <= '0;
         r_write_req     <= 1'b0;
         r_read_req      <= 1'b0;
         r_burstbegin    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (local_init_done && (w_wr_elig || w_rd_elig)) begin
                  r_burstbegin <= 1'b1;
                  if (w_pick_wr) begin
                     r_state         <= S_WR;
                     r_local_address <= wr_addr;
                     r_write_req     <= 1'b1;
                  end else begin
                     r_state         <= S_RD;
                     r_local_address <= rd_addr;
                     r_read_req      <= 1'b1;
                  end
               end
            end
            S_WR: begin
               // Address, data and burstbegin hold until local_ready.
               if (local_ready) begin
                  r_burstbegin <= 1'b0;
                  if (r_beat_cnt == LAST_BEAT) begin
                     r_beat_cnt    <= '0;
                     r_write_req   <= 1'b0;
                     r_last_served <= SRV_WRITE;
                     r_state       <= S_IDLE;
                  end else begin
                     r_beat_cnt <= r_beat_cnt + BCW'(1);
                  end
               end
            end
            S_RD: begin
               if (local_ready) begin
                  r_burstbegin  <= 1'b0;
                  r_read_req    <= 1'b0;
                  r_last_served <= SRV_READ;
                  r_state       <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Outstanding-read accounting; issue and completion in the same cycle cancel.
   always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
      if (!reset_phy_clk_n) begin
         r_ret_cnt <= '0;
         r_rd_out  <= '0;
      end else begin
         if (w_ret_cnt_en)
            r_ret_cnt <= (r_ret_cnt == LAST_BEAT) ? '0 : r_ret_cnt + BCW'(1);
         case ({w_rd_cmd_acc, w_ret_last})
            2'b10:   r_rd_out <= r_rd_out + OCW'(1);
            2'b01:   r_rd_out <= r_rd_out - OCW'(1);
            default: r_rd_out <= r_rd_out;
         endcase
      end
   end

   // Read return path, one register stage independent of the sequencer
   always_ff @(posedge phy_clk or negedge reset_phy_clk_n) begin
      if (!reset_phy_clk_n) begin
         r_rd_data_valid <= 1'b0;
         r_rd_data       <= '0;
      end else begin
         r_rd_data_valid <= local_rdata_valid;
         r_rd_data       <= local_rdata;
      end
   end

   assign local_address    = r_local_address;
   assign local_write_req  = r_write_req;
   assign local_read_req   = r_read_req;
   assign local_burstbegin = r_burstbegin;
   assign local_size       = 4'(BURST_LEN);
   assign local_be         = '1;
   assign local_wdata      = wr_data;
   assign wr_data_rd       = w_wr_beat_acc;
   assign wr_gnt           = w_wr_beat_acc & (r_beat_cnt == LAST_BEAT);
   assign rd_gnt           = w_rd_cmd_acc;
   assign rd_data_valid    = r_rd_data_valid;
   assign rd_data          = r_rd_data;
   assign busy             = (r_state != S_IDLE) | (r_rd_out != '0);

endmodule

// File: tb/tb_ddr2_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ddr2_port_arbiter
//
// Directed bench for ddr2_port_arbiter (ADDR_W=24, DATA_W=64, BURST_LEN=4,
// MAX_RD_OUT=2). Inputs change 1 ns after the rising edge and outputs are
// sampled 1-2 ns after it. The arbitration step follows the
// DDR2_ARB_WRITE_PRIORITY_EN build option.
// ---------------------------------------------------------------------------
module tb_ddr2_port_arbiter;

   localparam int ADDR_W = 24;
   localparam int DATA_W = 64;
   localparam int BL     = 4;
   localparam int MAXO   = 2;

   logic                phy_clk = 1'b0;
   logic                reset_phy_clk_n;
   logic                local_init_done;
   logic                wr_req;
   logic [ADDR_W-1:0]   wr_addr;
   logic [DATA_W-1:0]   wr_data;
   logic                wr_data_rd;
   logic                wr_gnt;
   logic                rd_req;
   logic [ADDR_W-1:0]   rd_addr;
   logic                rd_gnt;
   logic                rd_data_valid;
   logic [DATA_W-1:0]   rd_data;
   logic                busy;
   logic                local_ready;
   logic                local_burstbegin;
   logic [ADDR_W-1:0]   local_address;
   logic [3:0]          local_size;
   logic [DATA_W/8-1:0] local_be;
   logic                local_write_req;
   logic [DATA_W-1:0]   local_wdata;
   logic                local_read_req;
   logic                local_rdata_valid;
   logic [DATA_W-1:0]   local_rdata;

   int n_checks = 0;
   int n_errors = 0;
   int rg_cnt   = 0;

   ddr2_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BL), .MAX_RD_OUT(MAXO)
   ) dut (
      .phy_clk(phy_clk), .reset_phy_clk_n(reset_phy_clk_n),
      .local_init_done(local_init_done),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_data_rd(wr_data_rd), .wr_gnt(wr_gnt),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
      .rd_data_valid(rd_data_valid), .rd_data(rd_data), .busy(busy),
      .local_ready(local_ready), .local_burstbegin(local_burstbegin),
      .local_address(local_address), .local_size(local_size),
      .local_be(local_be), .local_write_req(local_write_req),
      .local_wdata(local_wdata), .local_read_req(local_read_req),
      .local_rdata_valid(local_rdata_valid), .local_rdata(local_rdata)
   );

   always #5 phy_clk = ~phy_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge phy_clk);
      #1;
   endtask

   // Drive n return beats (data base+k) and check the registered copy.
   task automatic inject_ret(input int n, input logic [63:0] base);
      for (int k = 0; k <= n; k++) begin
         tick();
         if (rd_gnt) rg_cnt++;
         if (k > 0) begin
            chk("ret_valid", rd_data_valid, 1);
            chk("ret_data", rd_data, base + 64'(k - 1));
         end
         if (k < n) begin
            local_rdata_valid = 1'b1;
            local_rdata       = base + 64'(k);
         end else begin
            local_rdata_valid = 1'b0;
         end
      end
      tick();
      if (rd_gnt) rg_cnt++;
      chk("ret_valid_end", rd_data_valid, 0);
   endtask

   // One write burst from an FWFT source whose word k is base+k.
   task automatic do_write(input logic [23:0] addr, input logic [63:0] base,
                           input int stall_at, input int stall_len,
                           input int exp_cyc, input bit drop_init);
      int cyc, pops, bbs, acc, gnt_c, idx;
      bit pop_q, done, data_ok, addr_ok;
      cyc = 0; pops = 0; bbs = 0; acc = 0; gnt_c = -1; idx = 0;
      pop_q = 0; done = 0; data_ok = 1; addr_ok = 1;
      wr_addr = addr;
      wr_data = base;
      wr_req  = 1'b1;
      for (int c = 0; c < 24 && !done; c++) begin
         tick();
         if (pop_q) begin
            idx++;
            wr_data = base + 64'(idx);
         end
         local_ready = !(c >= stall_at && c < stall_at + stall_len);
         if (drop_init && c == 1) local_init_done = 1'b0;
         #1;
         if (local_write_req) begin
            cyc++;
            if (local_address !== addr) addr_ok = 0;
         end
         if (local_burstbegin) bbs++;
         if (local_write_req && local_ready) begin
            if (local_wdata !== base + 64'(acc)) data_ok = 0;
            acc++;
         end
         pop_q = wr_data_rd;
         if (wr_data_rd) pops++;
         if (wr_gnt) begin
            gnt_c  = c;
            wr_req = 1'b0;
            done   = 1;
         end
      end
      wr_req = 1'b0;
      chk("wr_req_cycles", 64'(cyc), 64'(exp_cyc));
      chk("wr_pops", 64'(pops), 64'(BL));
      chk("wr_burstbegin_cycles", 64'(bbs), 1);
      chk("wr_gnt_cycle", 64'(gnt_c), 64'(exp_cyc - 1));
      chk("wr_beat_data", 64'(data_ok), 1);
      chk("wr_addr_held", 64'(addr_ok), 1);
      local_ready = 1'b1;
      tick();
      chk("wr_back_idle", local_write_req, 0);
      chk("wr_not_busy", busy, 0);
   endtask

   initial begin
      int n_clear;
      int ng;
      int ok;
      reset_phy_clk_n   = 1'b0;
      local_init_done   = 1'b0;
      wr_req            = 1'b0;
      rd_req            = 1'b0;
      wr_addr           = '0;
      rd_addr           = '0;
      wr_data           = '0;
      local_ready       = 1'b1;
      local_rdata_valid = 1'b1;
      local_rdata       = 64'h1234;
      n_clear           = 0;

      // Reset state
      repeat (3) tick();
      chk("rst_write_req", local_write_req, 0);
      chk("rst_read_req", local_read_req, 0);
      chk("rst_burstbegin", local_burstbegin, 0);
      chk("rst_wr_gnt", wr_gnt, 0);
      chk("rst_rd_gnt", rd_gnt, 0);
      chk("rst_wr_data_rd", wr_data_rd, 0);
      chk("rst_rd_valid", rd_data_valid, 0);
      chk("rst_rd_data", rd_data, 0);
      chk("rst_address", local_address, 0);
      chk("rst_be", local_be, 8'hFF);
      chk("rst_size", local_size, 4);
      chk("rst_busy", busy, 0);
      local_rdata_valid = 1'b0;
      reset_phy_clk_n   = 1'b1;
      tick();

      // No grant before calibration completes
      wr_req  = 1'b1;
      wr_addr = 24'h0000AA;
      ok = 1;
      repeat (3) begin
         tick();
         if (local_write_req || local_read_req) ok = 0;
      end
      chk("gate_no_cmd", 64'(ok), 1);
      wr_req = 1'b0;
      local_init_done = 1'b1;
      tick();

`ifndef DDR2_ARB_WRITE_PRIORITY_EN
      begin : rr_test
         int gc[4];
         logic [7:0] gk[4];
         wr_addr = 24'h000200;
         rd_addr = 24'h000300;
         wr_data = 64'h55;
         wr_req  = 1'b1;
         rd_req  = 1'b1;
         ng = 0;
         for (int c = 0; c < 30 && ng < 4; c++) begin
            tick();
            if (rd_gnt && ng == 1) begin
               chk("rr_rd_addr", local_address, 24'h000300);
               chk("rr_rd_burstbegin", local_burstbegin, 1);
            end
            if (wr_gnt) begin
               gk[ng] = "W"; gc[ng] = c; ng++;
            end else if (rd_gnt) begin
               gk[ng] = "R"; gc[ng] = c; ng++;
            end
         end
         wr_req = 1'b0;
         rd_req = 1'b0;
         chk("rr_order", {gk[0], gk[1], gk[2], gk[3]}, 32'h57525752);
         chk("rr_gnt0_cycle", 64'(gc[0]), 3);
         chk("rr_gnt1_cycle", 64'(gc[1]), 5);
         chk("rr_gnt2_cycle", 64'(gc[2]), 10);
         chk("rr_gnt3_cycle", 64'(gc[3]), 12);
         n_clear = 8;
      end
`else
      begin : prio_test
         int nw, nr, lat;
         wr_addr = 24'h000200;
         rd_addr = 24'h000300;
         wr_data = 64'h55;
         wr_req  = 1'b1;
         rd_req  = 1'b1;
         nw = 0; nr = 0; lat = -1;
         for (int c = 0; c < 40 && nw < 3; c++) begin
            tick();
            if (wr_gnt) nw++;
            if (rd_gnt) nr++;
         end
         wr_req = 1'b0;
         chk("prio_writes", 64'(nw), 3);
         chk("prio_no_reads", 64'(nr), 0);
         for (int c = 1; c <= 4 && lat < 0; c++) begin
            tick();
            if (rd_gnt) lat = c;
         end
         rd_req = 1'b0;
         chk("prio_rd_latency", 64'(lat), 2);
         n_clear = 4;
      end
`endif

      // Drain the reads issued above
      tick();
      chk("busy_with_reads", busy, 1);
      inject_ret(n_clear, 64'hC0);
      chk("drained_not_busy", busy, 0);

      // Returns with nothing outstanding are forwarded but not counted
      inject_ret(3, 64'hE00);
      chk("stray_not_busy", busy, 0);

      // Outstanding read limit
      rd_addr = 24'h000400;
      rd_req  = 1'b1;
      ng = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (rd_gnt) ng++;
      end
      chk("max_two_gnts", 64'(ng), 2);
      chk("max_busy", busy, 1);
      chk("max_no_cmd", local_read_req, 0);
      rg_cnt = 0;
      inject_ret(4, 64'hD0);
      rd_req = 1'b0;
      chk("max_third_gnt", 64'(rg_cnt), 1);
      tick();
      inject_ret(8, 64'hF00);
      chk("max_drained", busy, 0);

      // Single write, then a write with a 3-cycle stall at beat 2 during
      // which calibration drops
      do_write(24'h000100, 64'hA0, 99, 0, 4, 1'b0);
      do_write(24'h000180, 64'hB0, 2, 3, 7, 1'b1);
      wr_req = 1'b1;
      ok = 1;
      repeat (3) begin
         tick();
         if (local_write_req) ok = 0;
      end
      chk("init_low_no_grant", 64'(ok), 1);
      wr_req = 1'b0;
      local_init_done = 1'b1;
      tick();

      // Asynchronous reset mid-burst
      wr_addr = 24'h000500;
      wr_req  = 1'b1;
      tick();
      tick();
      #2 reset_phy_clk_n = 1'b0;
      #1;
      chk("arst_write_req", local_write_req, 0);
      chk("arst_burstbegin", local_burstbegin, 0);
      chk("arst_address", local_address, 0);
      chk("arst_wr_data_rd", wr_data_rd, 0);
      chk("arst_busy", busy, 0);
      wr_req = 1'b0;
      tick();
      reset_phy_clk_n = 1'b1;
      tick();
      chk("arst_stays_idle", local_write_req, 0);
      do_write(24'h000600, 64'hF0, 99, 0, 4, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/ddr2_port_arbiter.md
Name: ddr2_port_arbiter

Overview:
- Two-requester scheduler in front of the DDR2 controller local interface.
- Write port: camera frame-buffer write path. Read port: host readout path.
- Sequences fixed-length bursts, holds commands under local_ready backpressure, and limits outstanding read bursts.
- Runs in the phy_clk domain; sits between the pixel/host FIFOs and the memory interface.

Parameters:
- ADDR_W, 24, local address width in 64-bit words.
- DATA_W, 64, local data width.
- BURST_LEN, 4, beats per burst (1..8), driven on local_size.
- MAX_RD_OUT, 2, max read bursts issued but not fully returned (1..7).

Ports:
- phy_clk  in  1  controller PHY clock; all logic on its rising edge.
- reset_phy_clk_n  in  1  asynchronous, active-low reset.
- local_init_done  in  1  controller calibration done; no grants while low.
- wr_req  in  1  write burst request; held with wr_addr until wr_gnt.
- wr_addr  in  ADDR_W  write burst start address.
- wr_data  in  DATA_W  write data, first-word-fall-through from the requester FIFO.
- wr_data_rd  out  1  pop strobe for wr_data (beat accepted).
- wr_gnt  out  1  one-cycle pulse when the last write beat is accepted.
- rd_req  in  1  read burst request; held with rd_addr until rd_gnt.
- rd_addr  in  ADDR_W  read burst start address.
- rd_gnt  out  1  one-cycle pulse when the read command is accepted.
- rd_data_valid  out  1  returned read beat valid.
- rd_data  out  DATA_W  returned read beat.
- busy  out  1  state != IDLE or any read outstanding.
- local_ready  in  1  controller accepts command/beat this cycle.
- local_burstbegin  out  1  first beat of each command.
- local_address  out  ADDR_W  burst address.
- local_size  out  4  burst length, equals BURST_LEN.
- local_be  out  DATA_W/8  byte enables, constant all ones.
- local_write_req  out  1  write beat valid.
- local_wdata  out  DATA_W  write beat data (equals wr_data).
- local_read_req  out  1  read command valid.
- local_rdata_valid  in  1  read beat from the controller.
- local_rdata  in  DATA_W  read data from the controller.

Behaviour:
- Reset: all outputs 0 except local_be (all ones) and local_size (BURST_LEN). State IDLE, beat_cnt 0, rd_out 0, last_served = READ.
- IDLE:
  - If local_init_done=1, evaluate requests.
  - Eligible write: wr_req=1. Eligible read: rd_req=1 and rd_out < MAX_RD_OUT.
  - If only one is eligible, take it. If both are eligible, serve the one opposite to last_served (round-robin).
  - On grant, register the address into local_address. Next state is WR or RD.
  - Command appears on local_* the cycle after the request is sampled (latency 1).
- WR:
  - local_write_req=1 every cycle. local_burstbegin=1 only while beat_cnt=0.
  - local_wdata = wr_data. wr_data_rd = local_ready.
  - beat_cnt advances only on local_ready=1. Address, data and burstbegin are held while local_ready=0.
  - On acceptance of beat BURST_LEN-1: wr_gnt pulse, beat_cnt to 0, last_served = WRITE, go to IDLE.
- RD:
  - local_read_req=1 and local_burstbegin=1 held until local_ready=1.
  - On acceptance: rd_gnt pulse, rd_out+1, last_served = READ, go to IDLE.
- Read return:
  - rd_data_valid/rd_data are local_rdata_valid/local_rdata registered, latency 1. Independent of state.
  - ret_cnt counts returned beats; on beat BURST_LEN-1 it wraps and rd_out is decremented.
  - Simultaneous increment and decrement leaves rd_out unchanged.
  - rd_out never exceeds MAX_RD_OUT. A return with rd_out=0 is ignored for counting but still forwarded.
- local_init_done falling mid-burst: current burst completes; no new grants until it is high again.
- Request dropped before its grant: protocol violation. A burst already started still completes.
- Async reset mid-burst: immediate return to reset values. The controller is reset with it.
- Back-to-back bursts have a minimum of 1 IDLE cycle between commands.

Optional Feature:
- Macro: DDR2_ARB_WRITE_PRIORITY_EN.
- Defined: in IDLE, an eligible write always wins over a read and last_served is ignored. This guarantees camera write bandwidth; reads run only when wr_req=0.
- Undefined: round-robin as specified above.

Test Plan:
- Reset: hold reset_phy_clk_n=0 -> all req/gnt/valid outputs 0, local_be=8'hFF, local_size=4, busy=0.
- Single write, BURST_LEN=4, local_ready=1: wr_req with wr_addr=24'h000100 -> next cycle local_address=24'h000100, burstbegin high 1 cycle, write_req high 4 cycles, wr_data_rd 4 pulses, wr_gnt on the 4th beat.
- Write backpressure: drop local_ready for 3 cycles at beat 2 -> wdata, address and beat count are held; the burst takes 7 cycles; exactly 4 wr_data_rd pulses.
- Both requests held continuously (macro undefined) -> grant order W, R, W, R with wr_gnt/rd_gnt alternating.
- MAX_RD_OUT=2, rd_req held, no returns -> 2 rd_gnt then stall with busy=1. Inject 4 local_rdata_valid beats -> 3rd read issued; rd_data_valid mirrors them 1 cycle later.
- DDR2_ARB_WRITE_PRIORITY_EN defined, both held -> only writes granted; rd_gnt within 2 cycles after wr_req drops.
